magia_axi_print_mon: RTL and testbench

- Passive, synthesizable monitor on the tile's outbound AXI write path, alongside the L2 sim memory.
- Decodes writes to the stderr, stdout and end-of-computation addresses, tracking outstanding AW/W pairing in order.
- Emits a character stream with valid/ready handshake, error-code and EOC indications.
- Never drives AXI signals; the slave remains the sole responder.

---
 rtl/magia_axi_print_mon_if.sv | 34 +++
 rtl/magia_axi_print_mon.sv | 204 ++++++++++++++++++++
 tb/tb_magia_axi_print_mon.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/magia_axi_print_mon_if.sv
// Bundle of the observed AXI AW/W channels and the outgoing character stream
// used by the print monitor; the bench drives the master side.
interface magia_axi_print_mon_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  aw_valid_i;
  logic                  aw_ready_i;
  logic [ADDR_W-1:0]     aw_addr_i;
  logic [7:0]            aw_len_i;
  logic                  w_valid_i;
  logic                  w_ready_i;
  logic [DATA_W-1:0]     w_data_i;
  logic [DATA_W/8-1:0]   w_strb_i;
  logic                  w_last_i;
  logic                  char_valid_o;
  logic                  char_ready_i;
  logic [7:0]            char_o;
  logic                  char_is_err_o;

  modport master (
    output aw_valid_i, aw_ready_i, aw_addr_i, aw_len_i,
    output w_valid_i, w_ready_i, w_data_i, w_strb_i, w_last_i,
    output char_ready_i,
    input  char_valid_o, char_o, char_is_err_o
  );

  modport slave (
    input  aw_valid_i, aw_ready_i, aw_addr_i, aw_len_i,
    input  w_valid_i, w_ready_i, w_data_i, w_strb_i, w_last_i,
    input  char_ready_i,
    output char_valid_o, char_o, char_is_err_o
  );
endinterface

// File: rtl/magia_axi_print_mon.sv
// Passive AXI write-path monitor: turns stdout/stderr writes into a character
// stream and latches the end-of-computation exit code, with sticky error flags.
module magia_axi_print_mon #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                AW_DEPTH    = 8,
  parameter int                CHAR_DEPTH  = 16,
  parameter logic [ADDR_W-1:0] STDERR_ADDR = ADDR_W'(32'hFFFF_0000),
  parameter logic [ADDR_W-1:0] STDOUT_ADDR = ADDR_W'(32'hFFFF_0004),
  parameter logic [ADDR_W-1:0] EOC_ADDR    = ADDR_W'(32'hCC03_0000)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  magia_axi_print_mon_if.slave  bus,
  output logic                  eoc_o,
  output logic [31:0]           exit_code_o,
  output logic [3:0]            err_flags_o
);

  localparam int LANES = DATA_W / 8;
  localparam int AWP   = $clog2(AW_DEPTH);
  localparam int CHP   = $clog2(CHAR_DEPTH);
  localparam logic [AWP:0] AW_FULL = (AWP+1)'(AW_DEPTH);
  localparam logic [CHP:0] CH_FULL = (CHP+1)'(CHAR_DEPTH);

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_ERR   = 2'd1,
    CLS_OUT   = 2'd2,
    CLS_EOC   = 2'd3
  } cls_e;

  cls_e          aw_cls_mem [AW_DEPTH];
  logic [7:0]    aw_len_mem [AW_DEPTH];
  logic [7:0]    ch_mem     [CHAR_DEPTH];
  logic          ch_err_mem [CHAR_DEPTH];

  logic [AWP-1:0] aw_wr_q, aw_wr_d, aw_rd_q, aw_rd_d;
  logic [AWP:0]   aw_cnt_q, aw_cnt_d;
  logic [CHP-1:0] ch_wr_q, ch_wr_d, ch_rd_q, ch_rd_d;
  logic [CHP:0]   ch_cnt_q, ch_cnt_d;
  logic [8:0]     beat_q, beat_d;
  logic           eoc_q, eoc_d;
  logic [31:0]    exit_q, exit_d;
  logic [3:0]     err_q, err_d;

  logic                aw_hs, w_hs;
  cls_e                aw_cls;
  logic [DATA_W-1:0]   w_gated;
  logic [31:0]         eoc_val;
  logic [7:0]          lane_char;
  logic                beat_ok, bypass;
  cls_e                beat_cls;
  logic [8:0]          beat_len;
  logic                aw_push, aw_push_ok, aw_pop;
  logic                ch_push, ch_push_ok, ch_pop, ch_is_err;
  logic                ch_valid;

  assign aw_hs = bus.aw_valid_i & bus.aw_ready_i;
  assign w_hs  = bus.w_valid_i & bus.w_ready_i;

  always_comb begin
    aw_cls = CLS_OTHER;
    if (bus.aw_addr_i == STDERR_ADDR)      aw_cls = CLS_ERR;
    else if (bus.aw_addr_i == STDOUT_ADDR) aw_cls = CLS_OUT;
    else if (bus.aw_addr_i == EOC_ADDR)    aw_cls = CLS_EOC;
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_gated[gi*8 +: 8] = bus.w_strb_i[gi] ? bus.w_data_i[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Exit word is the low 32 bits of the strobe-gated beat, zero-extended on narrow buses.
  always_comb begin
    eoc_val = 32'h0;
    for (int i = 0; i < LANES; i++) begin
      if (i < 4) eoc_val[i*8 +: 8] = w_gated[i*8 +: 8];
    end
  end

  always_comb begin
    lane_char = 8'h00;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (bus.w_strb_i[i]) lane_char = bus.w_data_i[i*8 +: 8];
    end
  end

  always_comb begin
    beat_ok   = 1'b0;
    bypass    = 1'b0;
    beat_cls  = aw_cls_mem[aw_rd_q];
    beat_len  = {1'b0, aw_len_mem[aw_rd_q]};
    beat_d    = beat_q;
    err_d     = err_q;
    eoc_d     = eoc_q;
    exit_d    = exit_q;
    aw_pop    = 1'b0;
    ch_push   = 1'b0;
    ch_is_err = 1'b0;

    // An empty queue lets a same-cycle AW stand in as the head.
    if (w_hs) begin
      if (aw_cnt_q != '0) begin
        beat_ok = 1'b1;
      end else if (aw_hs) begin
        beat_ok  = 1'b1;
        bypass   = 1'b1;
        beat_cls = aw_cls;
        beat_len = {1'b0, bus.aw_len_i};
      end else begin
        err_d[2] = 1'b1;
      end
    end

    if (beat_ok) begin
      if (bus.w_last_i) begin
        beat_d = '0;
        aw_pop = !bypass;
        if (beat_q != beat_len) err_d[3] = 1'b1;
      end else begin
        if (beat_q >= beat_len) err_d[3] = 1'b1;
        if (beat_q != '1) beat_d = beat_q + 9'd1;
      end
      case (beat_cls)
        CLS_ERR, CLS_OUT: begin
          ch_push   = |bus.w_strb_i;
          ch_is_err = (beat_cls == CLS_ERR);
        end
        CLS_EOC: begin
          if (beat_q == '0 && eoc_val != 32'h0 && !eoc_q) begin
            eoc_d  = 1'b1;
            exit_d = eoc_val;
          end
        end
        default: ;
      endcase
    end

    // A bypassed single-beat burst completes immediately and never occupies the queue.
    aw_push    = aw_hs && !(bypass && bus.w_last_i);
    aw_push_ok = aw_push && ((aw_cnt_q != AW_FULL) || aw_pop);
    if (aw_push && !aw_push_ok) err_d[0] = 1'b1;

    ch_pop     = (ch_cnt_q != '0) && bus.char_ready_i;
    ch_push_ok = ch_push && ((ch_cnt_q != CH_FULL) || ch_pop);
    if (ch_push && !ch_push_ok) err_d[1] = 1'b1;

    aw_wr_d  = aw_push_ok ? aw_wr_q + 1'b1 : aw_wr_q;
    aw_rd_d  = aw_pop ? aw_rd_q + 1'b1 : aw_rd_q;
    aw_cnt_d = aw_cnt_q + (AWP+1)'(aw_push_ok) - (AWP+1)'(aw_pop);
    ch_wr_d  = ch_push_ok ? ch_wr_q + 1'b1 : ch_wr_q;
    ch_rd_d  = ch_pop ? ch_rd_q + 1'b1 : ch_rd_q;
    ch_cnt_d = ch_cnt_q + (CHP+1)'(ch_push_ok) - (CHP+1)'(ch_pop);
  end

  always_ff @(posedge clk_i) begin
    if (aw_push_ok) begin
      aw_cls_mem[aw_wr_q] <= aw_cls;
      aw_len_mem[aw_wr_q] <= bus.aw_len_i;
    end
    if (ch_push_ok) begin
      ch_mem[ch_wr_q]     <= lane_char;
      ch_err_mem[ch_wr_q] <= ch_is_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_wr_q  <= '0;
      aw_rd_q  <= '0;
      aw_cnt_q <= '0;
      ch_wr_q  <= '0;
      ch_rd_q  <= '0;
      ch_cnt_q <= '0;
      beat_q   <= '0;
      eoc_q    <= 1'b0;
      exit_q   <= 32'h0;
      err_q    <= 4'h0;
    end else begin
      aw_wr_q  <= aw_wr_d;
      aw_rd_q  <= aw_rd_d;
      aw_cnt_q <= aw_cnt_d;
      ch_wr_q  <= ch_wr_d;
      ch_rd_q  <= ch_rd_d;
      ch_cnt_q <= ch_cnt_d;
      beat_q   <= beat_d;
      eoc_q    <= eoc_d;
      exit_q   <= exit_d;
      err_q    <= err_d;
    end
  end

  // Head is read through so the character shows the cycle after its W beat.
  assign ch_valid          = (ch_cnt_q != '0);
  assign bus.char_valid_o  = ch_valid;
  assign bus.char_o        = ch_valid ? ch_mem[ch_rd_q] : 8'h00;
  assign bus.char_is_err_o = ch_valid ? ch_err_mem[ch_rd_q] : 1'b0;
  assign eoc_o             = eoc_q;
  assign exit_code_o       = exit_q;
  assign err_flags_o       = err_q;

endmodule

// File: tb/tb_magia_axi_print_mon.sv
// Randomized scoreboard bench for the AXI print monitor: a queue-based model
// predicts the character stream, EOC and error flags from observed handshakes.
module tb_magia_axi_print_mon;

  localparam logic [31:0] A_ERR = 32'hFFFF_0000;
  localparam logic [31:0] A_OUT = 32'hFFFF_0004;
  localparam logic [31:0] A_EOC = 32'hCC03_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        eoc;
  logic [31:0] exit_code;
  logic [3:0]  err_flags;

  always #5 clk = ~clk;

  magia_axi_print_mon_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  magia_axi_print_mon #(
    .ADDR_W(32), .DATA_W(32), .AW_DEPTH(8), .CHAR_DEPTH(16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus_if),
    .eoc_o       (eoc),
    .exit_code_o (exit_code),
    .err_flags_o (err_flags)
  );

  typedef struct { int cls; int len; } aw_t;
  typedef struct packed { logic [7:0] c; logic e; } ch_t;

  int    checks = 0;
  int    errors = 0;
  int    acc_cnt = 0;
  int    ready_mode = 1;

  aw_t   awq[$];
  ch_t   exp_q[$];
  int    occ, beats, m_lane;
  logic  m_eoc;
  logic [31:0] m_exit, m_val;
  logic [3:0]  m_err;
  logic  m_aw_done;
  aw_t   m_new, m_cur;
  ch_t   mon_e;

  logic [31:0] rb_addr [3];
  int          rb_len  [3];
  int          nb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [31:0] a);
    if (a == A_ERR) return 1;
    if (a == A_OUT) return 2;
    if (a == A_EOC) return 3;
    return 0;
  endfunction

  // Reference model: applies the observed handshakes at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      awq.delete();
      exp_q.delete();
      occ = 0; beats = 0; m_eoc = 1'b0; m_exit = 32'h0; m_err = 4'h0;
    end else begin
      m_aw_done = 1'b0;
      m_new.cls = cls_of(bus_if.aw_addr_i);
      m_new.len = int'(bus_if.aw_len_i);
      if (occ > 0 && bus_if.char_ready_i) occ--;
      if (bus_if.w_valid_i && bus_if.w_ready_i && awq.size() == 0 &&
          bus_if.aw_valid_i && bus_if.aw_ready_i) begin
        awq.push_back(m_new);
        m_aw_done = 1'b1;
      end
      if (bus_if.w_valid_i && bus_if.w_ready_i) begin
        if (awq.size() == 0) begin
          m_err[2] = 1'b1;
        end else begin
          m_cur = awq[0];
          if (m_cur.cls == 1 || m_cur.cls == 2) begin
            m_lane = -1;
            for (int i = 0; i < 4; i++)
              if (m_lane < 0 && bus_if.w_strb_i[i]) m_lane = i;
            if (m_lane >= 0) begin
              if (occ < 16) begin
                exp_q.push_back('{c: bus_if.w_data_i[m_lane*8 +: 8], e: (m_cur.cls == 1)});
                occ++;
              end else begin
                m_err[1] = 1'b1;
              end
            end
          end
          if (m_cur.cls == 3 && beats == 0) begin
            m_val = 32'h0;
            for (int i = 0; i < 4; i++)
              if (bus_if.w_strb_i[i]) m_val[i*8 +: 8] = bus_if.w_data_i[i*8 +: 8];
            if (m_val != 0 && !m_eoc) begin
              m_eoc = 1'b1;
              m_exit = m_val;
            end
          end
          if (bus_if.w_last_i) begin
            if (beats != m_cur.len) m_err[3] = 1'b1;
            void'(awq.pop_front());
            beats = 0;
          end else begin
            beats++;
            if (beats > m_cur.len) m_err[3] = 1'b1;
          end
        end
      end
      if (bus_if.aw_valid_i && bus_if.aw_ready_i && !m_aw_done) begin
        if (awq.size() < 8) awq.push_back(m_new);
        else m_err[0] = 1'b1;
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("char_valid", 32'(bus_if.char_valid_o), 32'(exp_q.size() != 0));
      if (bus_if.char_valid_o && bus_if.char_ready_i && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("char", 32'(bus_if.char_o), 32'(mon_e.c));
        chk("char_is_err", 32'(bus_if.char_is_err_o), 32'(mon_e.e));
        acc_cnt++;
        $display("char 0x%02h is_err=%0d at %0t", bus_if.char_o, bus_if.char_is_err_o, $time);
      end
      chk("eoc", 32'(eoc), 32'(m_eoc));
      chk("exit_code", exit_code, m_exit);
      chk("err_flags", 32'(err_flags), 32'(m_err));
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus_if.char_ready_i = 1'b0;
      1:       bus_if.char_ready_i = 1'b1;
      default: bus_if.char_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); tick(); rst = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input int stall);
    tick();
    bus_if.aw_valid_i = 1'b1; bus_if.aw_ready_i = 1'b0;
    bus_if.aw_addr_i = a; bus_if.aw_len_i = l;
    repeat (stall) tick();
    bus_if.aw_ready_i = 1'b1;
    tick();
    bus_if.aw_valid_i = 1'b0; bus_if.aw_ready_i = 1'b0;
    $display("aw addr=0x%08h len=%0d", a, l);
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last, input int stall);
    tick();
    bus_if.w_valid_i = 1'b1; bus_if.w_ready_i = 1'b0;
    bus_if.w_data_i = d; bus_if.w_strb_i = s; bus_if.w_last_i = last;
    repeat (stall) tick();
    bus_if.w_ready_i = 1'b1;
    tick();
    bus_if.w_valid_i = 1'b0; bus_if.w_ready_i = 1'b0; bus_if.w_last_i = 1'b0;
    $display("w data=0x%08h strb=%b last=%0d", d, s, last);
  endtask

  task automatic do_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    tick();
    bus_if.aw_valid_i = 1'b1; bus_if.aw_ready_i = 1'b1;
    bus_if.aw_addr_i = a; bus_if.aw_len_i = 8'd0;
    bus_if.w_valid_i = 1'b1; bus_if.w_ready_i = 1'b1;
    bus_if.w_data_i = d; bus_if.w_strb_i = s; bus_if.w_last_i = 1'b1;
    tick();
    bus_if.aw_valid_i = 1'b0; bus_if.aw_ready_i = 1'b0;
    bus_if.w_valid_i = 1'b0; bus_if.w_ready_i = 1'b0; bus_if.w_last_i = 1'b0;
    $display("aw+w addr=0x%08h data=0x%08h strb=%b", a, d, s);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    tick(); tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.aw_valid_i = 1'b0; bus_if.aw_ready_i = 1'b0;
    bus_if.aw_addr_i = 32'h0; bus_if.aw_len_i = 8'h0;
    bus_if.w_valid_i = 1'b0; bus_if.w_ready_i = 1'b0;
    bus_if.w_data_i = 32'h0; bus_if.w_strb_i = 4'h0; bus_if.w_last_i = 1'b0;
    bus_if.char_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_char_valid", 32'(bus_if.char_valid_o), 32'd0);
    chk("rst_char", 32'(bus_if.char_o), 32'd0);
    chk("rst_char_is_err", 32'(bus_if.char_is_err_o), 32'd0);
    chk("rst_eoc", 32'(eoc), 32'd0);
    chk("rst_exit_code", exit_code, 32'd0);
    chk("rst_err_flags", 32'(err_flags), 32'd0);

    // stdout "Hi\n", stderr byte on lane 1
    do_aw(A_OUT, 8'd0, 0);  do_w(32'h0000_0048, 4'b0001, 1'b1, 0);
    do_aw_w(A_OUT, 32'h0000_0069, 4'b0001);
    do_aw(A_OUT, 8'd0, 1);  do_w(32'h0000_000A, 4'b0001, 1'b1, 2);
    do_aw(A_ERR, 8'd0, 0);  do_w(32'h0000_0500, 4'b0010, 1'b1, 0);
    drain(50);

    // end of computation
    do_aw(A_EOC, 8'd0, 0); do_w(32'h0, 4'hF, 1'b1, 0);
    chk("eoc_after_zero", 32'(eoc), 32'd0);
    do_aw(A_EOC, 8'd0, 0); do_w(32'h0000_002A, 4'hF, 1'b1, 0);
    chk("eoc_after_2a", 32'(eoc), 32'd1);
    chk("exit_after_2a", exit_code, 32'h2A);
    do_aw(A_EOC, 8'd0, 0); do_w(32'h0000_0007, 4'hF, 1'b1, 0);
    chk("eoc_after_7", 32'(eoc), 32'd1);
    chk("exit_after_7", exit_code, 32'h2A);

    // interleaved OTHER len=3 then OUT len=0
    acc_cnt = 0;
    do_aw(32'h8000_0000, 8'd3, 0);
    do_aw(A_OUT, 8'd0, 0);
    for (int i = 0; i < 4; i++) do_w($urandom, 4'hF, i == 3, 0);
    do_w(32'h0000_0021, 4'b0001, 1'b1, 0);
    drain(50);
    chk("interleave_chars", 32'(acc_cnt), 32'd1);
    chk("interleave_flags", 32'(err_flags), 32'd0);

    // backpressure overflow
    ready_mode = 0;
    tick(); tick();
    for (int i = 0; i < 17; i++) do_aw_w(A_OUT, 32'h61 + 32'(i), 4'b0001);
    chk("overflow_flag", 32'(err_flags[1]), 32'd1);
    acc_cnt = 0;
    ready_mode = 1;
    drain(100);
    chk("overflow_drain_count", 32'(acc_cnt), 32'd16);

    // randomized traffic with random consumer readiness
    ready_mode = 2;
    repeat (40) begin
      nb = $urandom_range(1, 3);
      if (nb == 1 && $urandom_range(0, 2) == 0) begin
        do_aw_w(($urandom_range(0, 1) != 0) ? A_OUT : A_ERR, $urandom, 4'($urandom));
      end else begin
        for (int b = 0; b < nb; b++) begin
          case ($urandom_range(0, 3))
            0:       rb_addr[b] = A_ERR;
            1:       rb_addr[b] = A_OUT;
            2:       rb_addr[b] = A_EOC;
            default: rb_addr[b] = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
          endcase
          rb_len[b] = $urandom_range(0, 3);
          do_aw(rb_addr[b], 8'(rb_len[b]), $urandom_range(0, 2));
        end
        for (int b = 0; b < nb; b++)
          for (int k = 0; k <= rb_len[b]; k++)
            do_w($urandom, 4'($urandom), k == rb_len[b], $urandom_range(0, 1));
      end
    end
    ready_mode = 1;
    drain(200);

    // protocol errors, each from a clean reset
    do_reset();
    do_w(32'h0000_0041, 4'b0001, 1'b1, 0);
    chk("unmatched_w", 32'(err_flags), 32'b0100);

    do_reset();
    do_aw(32'h8000_0000, 8'd1, 0);
    do_w(32'h0, 4'hF, 1'b1, 0);
    chk("len_mismatch", 32'(err_flags), 32'b1000);

    do_reset();
    for (int i = 0; i < 9; i++) do_aw(32'h8000_0000, 8'd0, 0);
    chk("aw_overflow", 32'(err_flags), 32'b0001);

    do_reset();
    do_aw(A_OUT, 8'd2, 0);
    do_w(32'h0000_0078, 4'b0001, 1'b0, 0);
    do_reset();
    do_w(32'h0000_0079, 4'b0001, 1'b0, 0);
    do_w(32'h0000_007A, 4'b0001, 1'b1, 0);
    chk("reset_mid_burst", 32'(err_flags), 32'b0100);
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
